pic_rom_arbiter: RTL and testbench



---
 rtl/pic_rom_pkg.sv | 23 ++
 rtl/pic_rom_tag_pipe.sv | 31 +++
 rtl/pic_rom_arbiter.sv | 140 ++++++++++++++
 tb/tb_pic_rom_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_rom_pkg.sv
// Shared types for the PicROM read arbiter: owner ids, arbiter state, tags.
// Imported by pic_rom_tag_pipe and pic_rom_arbiter.
package pic_rom_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        OWN_SOBEL = 1'b0,
        OWN_AUX   = 1'b1
    } owner_e;

    typedef enum logic {
        LAST0 = 1'b0,
        LAST1 = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

endpackage

// File: rtl/pic_rom_tag_pipe.sv
// Shift register of read tags; tail lines up with ROM douta of that read.
// Synchronous clear drops every in-flight read.
module pic_rom_tag_pipe
    import pic_rom_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_clr,
    input  tag_t i_tag,
    output tag_t o_tag
);

    tag_t r_pipe [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_tag = r_pipe[DEPTH-1];

endmodule

// File: rtl/pic_rom_arbiter.sv
// Two-port read arbiter in front of the single-port PicROM (fclk domain).
// PIC_ROM_ARB_RR_EN selects round-robin instead of priority + starvation guard.
module pic_rom_arbiter
    import pic_rom_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int ROM_LAT      = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              fclk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_pick1;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    tag_t              w_tag_in;
    tag_t              w_tag_out;

`ifdef PIC_ROM_ARB_RR_EN
    assign w_pick1 = (r_state == LAST0);
`else
    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [CNT_W-1:0] r_starve;

    // Port 1 overrides only once it has been denied STARVE_LIMIT cycles in a row.
    assign w_pick1 = (STARVE_LIMIT != 0) && (r_starve == CNT_W'(STARVE_LIMIT));

    always_ff @(posedge fclk) begin
        if (rst || !req1 || w_gnt1) begin
            r_starve <= '0;
        end else if (r_starve != CNT_W'(STARVE_LIMIT)) begin
            r_starve <= r_starve + CNT_W'(1);
        end
    end
`endif

    always_ff @(posedge fclk) begin
        if (rst) begin
            r_state <= LAST1;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = r_state;
        if (!rst) begin
            unique case ({req1, req0})
                2'b01:   w_gnt0 = 1'b1;
                2'b10:   w_gnt1 = 1'b1;
                2'b11: begin
                    w_gnt0 = !w_pick1;
                    w_gnt1 = w_pick1;
                end
                default: ;
            endcase
            if (w_gnt0) begin
                w_state_nxt = LAST0;
            end else if (w_gnt1) begin
                w_state_nxt = LAST1;
            end
        end
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            r_rom_addr <= '0;
        end else if (w_gnt0) begin
            r_rom_addr <= addr0;
        end else if (w_gnt1) begin
            r_rom_addr <= addr1;
        end
    end

    always_comb begin
        w_tag_in       = '0;
        w_tag_in.valid = w_gnt0 | w_gnt1;
        w_tag_in.owner = w_gnt1 ? OWN_AUX : OWN_SOBEL;
    end

    pic_rom_tag_pipe #(
        .DEPTH (ROM_LAT + 1)
    ) u_tags (
        .i_clk (fclk),
        .i_clr (rst),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    always_ff @(posedge fclk) begin
        if (rst) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= w_tag_out.valid && (w_tag_out.owner == OWN_SOBEL);
            r_rvalid1 <= w_tag_out.valid && (w_tag_out.owner == OWN_AUX);
            if (w_tag_out.valid && (w_tag_out.owner == OWN_SOBEL)) begin
                r_rdata0 <= rom_data;
            end
            if (w_tag_out.valid && (w_tag_out.owner == OWN_AUX)) begin
                r_rdata1 <= rom_data;
            end
        end
    end

    assign gnt0     = w_gnt0;
    assign gnt1     = w_gnt1;
    assign rom_addr = r_rom_addr;
    assign rvalid0  = r_rvalid0;
    assign rvalid1  = r_rvalid1;
    assign rdata0   = r_rdata0;
    assign rdata1   = r_rdata1;

endmodule

// File: tb/tb_pic_rom_arbiter.sv
// Bench for pic_rom_arbiter: directed scenarios plus randomized traffic
// against a cycle-level reference model; ROM returns addr[7:0] after 1 cycle.
`timescale 1ns/1ps
module tb_pic_rom_arbiter;

    localparam int LAT = 1;
    localparam int LIM = 8;

    logic        fclk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [15:0] addr0 = '0;
    logic [15:0] addr1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0]  rdata0, rdata1, rom_data;
    logic [15:0] rom_addr;
    logic        s_gnt0, s_gnt1, s_rvalid0, s_rvalid1;
    logic [7:0]  s_rdata0, s_rdata1, s_rom_data;
    logic [15:0] s_rom_addr;

    int vectors = 0;
    int errors = 0;

    always #5 fclk = ~fclk;

    pic_rom_arbiter #(.ADDR_W(16), .DATA_W(8), .ROM_LAT(LAT), .STARVE_LIMIT(LIM)) dut (
        .fclk(fclk), .rst(rst),
        .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .rom_addr(rom_addr), .rom_data(rom_data)
    );

    pic_rom_arbiter #(.ADDR_W(16), .DATA_W(8), .ROM_LAT(LAT), .STARVE_LIMIT(0)) dut_s (
        .fclk(fclk), .rst(rst),
        .req0(req0), .addr0(addr0), .gnt0(s_gnt0), .rvalid0(s_rvalid0), .rdata0(s_rdata0),
        .req1(req1), .addr1(addr1), .gnt1(s_gnt1), .rvalid1(s_rvalid1), .rdata1(s_rdata1),
        .rom_addr(s_rom_addr), .rom_data(s_rom_data)
    );

    always @(posedge fclk) begin
        rom_data   <= rom_addr[7:0];
        s_rom_data <= s_rom_addr[7:0];
    end

    // Reference model: expected grants, rom_addr and a table of due returns.
    int          cyc = 0;
    int          m_last = 1;
    int          m_starve = 0;
    logic [15:0] m_rom = '0;
    bit          dv [2][16];
    logic [7:0]  dd [2][16];

    function automatic int exp_grant();
        if (rst || (!req0 && !req1)) return -1;
        if (!req1) return 0;
        if (!req0) return 1;
`ifdef PIC_ROM_ARB_RR_EN
        return (m_last == 1) ? 0 : 1;
`else
        return (LIM != 0 && m_starve >= LIM) ? 1 : 0;
`endif
    endfunction

    always @(posedge fclk) begin : model
        int g;
        int due;
        g = exp_grant();
        cyc++;
        dv[0][(cyc - 1) & 15] = 1'b0;
        dv[1][(cyc - 1) & 15] = 1'b0;
        due = (cyc + LAT + 1) & 15;
        if (rst) begin
            m_last = 1;
            m_starve = 0;
            m_rom = '0;
            for (int i = 0; i < 16; i++) begin
                dv[0][i] = 1'b0;
                dv[1][i] = 1'b0;
            end
        end else begin
            if (g == 0) begin
                m_last = 0;
                m_rom = addr0;
                dv[0][due] = 1'b1;
                dd[0][due] = addr0[7:0];
            end else if (g == 1) begin
                m_last = 1;
                m_rom = addr1;
                dv[1][due] = 1'b1;
                dd[1][due] = addr1[7:0];
            end
            if (req1 && g != 1) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
            else m_starve = 0;
        end
    end

    task automatic step();
        @(posedge fclk);
        #1;
    endtask

    task automatic idle(input int n);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (n) step();
    endtask

    task automatic test_reset();
        repeat (2) step();
        req0 = 1'b1;
        req1 = 1'b1;
        @(negedge fclk);
        vectors++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt got=%b%b exp=00", gnt0, gnt1);
        end
        step();
        rst = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge fclk);
        vectors++;
        if ({rvalid0, rvalid1, rdata0, rdata1, rom_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outs got v=%b%b d0=%h d1=%h a=%h exp all 0",
                     rvalid0, rvalid1, rdata0, rdata1, rom_addr);
        end
    endtask

    task automatic test_single();
        step();
        req0 = 1'b1;
        addr0 = 16'h1234;
        @(negedge fclk);
        vectors++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL single_gnt got=%b%b exp=10", gnt0, gnt1);
        end
        step();
        req0 = 1'b0;
        @(negedge fclk);
        vectors++;
        if (rom_addr !== 16'h1234) begin
            errors++;
            $display("FAIL single_addr got=%h exp=1234", rom_addr);
        end
        for (int c = 2; c <= 4; c++) begin
            step();
            @(negedge fclk);
            vectors++;
            if (rvalid0 !== (c == 3) || rvalid1 !== 1'b0) begin
                errors++;
                $display("FAIL single_rvalid c=%0d got=%b%b exp=%b0", c, rvalid0, rvalid1, c == 3);
            end
            if (c == 3) begin
                vectors++;
                if (rdata0 !== 8'h34) begin
                    errors++;
                    $display("FAIL single_rdata got=%h exp=34", rdata0);
                end
            end
        end
    endtask

    task automatic test_contention();
        for (int k = 0; k < 27; k++) begin
            step();
            req0 = 1'b1;
            req1 = 1'b1;
            addr0 = 16'h0A00;
            addr1 = 16'h0BCD;
            @(negedge fclk);
            vectors++;
            if (gnt1 !== (k % 9 == 8) || gnt0 !== (k % 9 != 8)) begin
                errors++;
                $display("FAIL contention k=%0d got=%b%b exp gnt1=%b", k, gnt0, gnt1, k % 9 == 8);
            end
        end
        idle(5);
    endtask

    task automatic test_strict();
        for (int k = 0; k < 100; k++) begin
            step();
            req0 = 1'b1;
            req1 = 1'b1;
            @(negedge fclk);
            vectors++;
            if (s_gnt1 !== 1'b0 || s_gnt0 !== 1'b1) begin
                errors++;
                $display("FAIL strict k=%0d got=%b%b exp=10", k, s_gnt0, s_gnt1);
            end
        end
        idle(5);
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 8; c++) begin
            step();
            req0 = (c < 4);
            addr0 = 16'(c);
            req1 = 1'b0;
            @(negedge fclk);
            vectors++;
            if (gnt0 !== (c < 4) || rvalid0 !== (c >= 3 && c <= 6)) begin
                errors++;
                $display("FAIL b2b c=%0d got gnt0=%b rvalid0=%b", c, gnt0, rvalid0);
            end
            if (c >= 3 && c <= 6) begin
                vectors++;
                if (rdata0 !== 8'(c - 3)) begin
                    errors++;
                    $display("FAIL b2b_data c=%0d got=%h exp=%h", c, rdata0, 8'(c - 3));
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        step();
        req0 = 1'b1;
        addr0 = 16'h77AB;
        @(negedge fclk);
        vectors++;
        if (gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL mid_gnt got=%b exp=1", gnt0);
        end
        step();
        rst = 1'b1;
        req1 = 1'b1;
        @(negedge fclk);
        vectors++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_gnt got=%b%b exp=00", gnt0, gnt1);
        end
        step();
        rst = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge fclk);
        vectors++;
        if ({rvalid0, rvalid1, rdata0, rdata1, rom_addr} !== '0) begin
            errors++;
            $display("FAIL mid_outs got v=%b%b d0=%h d1=%h a=%h exp all 0",
                     rvalid0, rvalid1, rdata0, rdata1, rom_addr);
        end
        for (int c = 3; c <= 5; c++) begin
            step();
            @(negedge fclk);
            vectors++;
            if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
                errors++;
                $display("FAIL mid_drop c=%0d got=%b%b exp=00", c, rvalid0, rvalid1);
            end
        end
        step();
        req1 = 1'b1;
        addr1 = 16'h00C3;
        @(negedge fclk);
        vectors++;
        if (gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL mid_regnt got=%b exp=1", gnt1);
        end
        step();
        req1 = 1'b0;
        repeat (2) step();
        @(negedge fclk);
        vectors++;
        if (rvalid1 !== 1'b1 || rdata1 !== 8'hC3 || rvalid0 !== 1'b0) begin
            errors++;
            $display("FAIL mid_return got v1=%b d1=%h v0=%b exp 1 c3 0", rvalid1, rdata1, rvalid0);
        end
        idle(4);
    endtask

    task automatic test_rr();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) step();
            req0 = 1'b1;
            req1 = 1'b1;
            addr0 = 16'h0100 + 16'(k);
            addr1 = 16'h0200 + 16'(k);
            @(negedge fclk);
            vectors++;
            if (gnt0 !== (k % 2 == 0) || gnt1 !== (k % 2 == 1)) begin
                errors++;
                $display("FAIL rr_gnt k=%0d got=%b%b", k, gnt0, gnt1);
            end
            vectors++;
            if (rvalid0 !== (k >= 3 && (k - 3) % 2 == 0) || rvalid1 !== (k >= 3 && (k - 3) % 2 == 1)) begin
                errors++;
                $display("FAIL rr_rvalid k=%0d got=%b%b", k, rvalid0, rvalid1);
            end
            if (k >= 3) begin
                vectors++;
                if ((rvalid0 ? rdata0 : rdata1) !== 8'(k - 3)) begin
                    errors++;
                    $display("FAIL rr_rdata k=%0d got=%h/%h exp=%h", k, rdata0, rdata1, 8'(k - 3));
                end
            end
        end
        idle(5);
    endtask

    task automatic test_random();
        int eg;
        int p;
        for (int k = 0; k < 1500; k++) begin
            step();
            p = (k < 750) ? 7 : 4;
            rst = ($urandom_range(0, 99) == 0);
            req0 = ($urandom_range(0, 7) < p);
            req1 = ($urandom_range(0, 7) < p);
            addr0 = 16'($urandom);
            addr1 = 16'($urandom);
            @(negedge fclk);
            eg = exp_grant();
            vectors++;
            if (gnt0 !== (eg == 0) || gnt1 !== (eg == 1)) begin
                errors++;
                $display("FAIL rnd_gnt cyc=%0d got=%b%b exp=%0d", cyc, gnt0, gnt1, eg);
            end
            vectors++;
            if (rvalid0 !== dv[0][cyc & 15] || rvalid1 !== dv[1][cyc & 15]) begin
                errors++;
                $display("FAIL rnd_rvalid cyc=%0d got=%b%b exp=%b%b", cyc,
                         rvalid0, rvalid1, dv[0][cyc & 15], dv[1][cyc & 15]);
            end
            vectors++;
            if ((rvalid0 && rdata0 !== dd[0][cyc & 15]) || (rvalid1 && rdata1 !== dd[1][cyc & 15])) begin
                errors++;
                $display("FAIL rnd_rdata cyc=%0d got=%h/%h exp=%h/%h", cyc,
                         rdata0, rdata1, dd[0][cyc & 15], dd[1][cyc & 15]);
            end
            vectors++;
            if (rom_addr !== m_rom) begin
                errors++;
                $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, rom_addr, m_rom);
            end
        end
        rst = 1'b0;
        idle(5);
    endtask

    initial begin
        test_reset();
        test_single();
`ifndef PIC_ROM_ARB_RR_EN
        test_contention();
        test_strict();
`endif
        idle(4);
        test_back_to_back();
        test_reset_midflight();
`ifdef PIC_ROM_ARB_RR_EN
        test_rr();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
